if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue RV32I core; sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory byte address. Captures the instruction word returned in the same cycle.
- Delivers {pc, inst} pairs to decode through a small registered buffer with a valid/ready handshake.
- Handles redirects from execute (branch/jump/trap) by flushing the buffer and reloading the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch buffer entries; must be a power of two and at least 2.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_addr  output  32  byte address to instruction memory; equals the pc register (no combinational input path).
imem_data  input  32  instruction word from memory, valid in the same cycle as imem_addr.
redirect_valid  input  1  execute requests a PC change this cycle.
redirect_pc  input  32  target byte address.
out_valid  output  1  buffer head holds a valid entry.
out_ready  input  1  decode accepts the head entry this cycle.
out_pc  output  32  PC of the head entry.
out_inst  output  32  instruction of the head entry; 32'h0000_0013 (NOP) when the entry is misaligned.
out_misaligned  output  1  head entry came from a PC with pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - pc = RESET_PC, count = 0, halted = 0.
  - out_valid = 0, out_pc = 0, out_inst = NOP, out_misaligned = 0.
- Definitions:
  - pop = out_valid & out_ready.
  - push = !redirect_valid & !halted & (count < DEPTH | pop).
- Push: writes {pc, imem_data, pc[1:0]!=0} at the tail. Then pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Latency: an entry pushed at edge N is visible at the head (out_valid = 1) in cycle N+1. From reset release, the first entry appears after one edge.
- Pop: head advances. Push and pop in the same cycle with a full buffer are legal; count is unchanged.
- Stall: when out_ready = 0 and the buffer is full, pc holds, imem_addr is stable, and head outputs hold their values.
- Redirect (dominates everything):
  - count <= 0, halted <= 0, pc <= redirect_pc.
  - No push and no effective pop that cycle.
  - out_valid = 0 in the next cycle. The target instruction reaches the head two edges after the redirect cycle.
- Misaligned PC (reachable only via redirect):
  - The entry is pushed with the misaligned flag set and inst replaced by NOP.
  - halted <= 1; no further pushes until the next redirect.
  - The entry still pops normally.
- Output stability: head fields are held while out_valid = 1 and out_ready = 0. This is required by the handshake and must be checked by an assertion.
- Buffer pointers are log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits, wrapping naturally.

Decomposition:
- Package if_pkg holds:
  - XLEN = 32 and INST_NOP = 32'h0000_0013.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0], misaligned}.
- Sub-module fetch_buffer: a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; async active-low reset; push/pop/flush inputs; full/empty/head outputs.
  - flush has priority over push/pop.
- if_stage contains the pc register, halted flag, push logic and output mapping.

Test Plan:
- Reset release, out_ready = 1, memory preloaded with word i at index i -> consecutive cycles give out_pc = 0, 4, 8, 12 with out_inst = word 0, 1, 2, 3; one entry per cycle.
- out_ready = 0 for 5 cycles after the first entry -> count saturates at 2 and pc holds at 8; head stays pc 0. On release, pcs 0, 4, 8 follow with no gap or duplicate.
- Buffer full, redirect_valid = 1 with redirect_pc = 32'h0000_0100 and out_ready = 1 in the same cycle -> next cycle out_valid = 0; one cycle later out_pc = 0x100; old entries are never delivered.
- redirect_pc = 32'h0000_0102 -> one entry with out_pc = 0x102, out_misaligned = 1, out_inst = NOP, then out_valid stays 0. A redirect to 0x200 resumes normal fetch.
- Redirect to 32'hFFFF_FFFC -> entries at 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst_n mid-stream while out_valid = 1 -> all outputs return to reset values immediately (asynchronously). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Defines the {pc, inst, misaligned} entry carried from fetch to decode.
package if_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries; a push is visible at the head one edge later.
// A push is dropped when the buffer is full and no pop frees a slot; flush overrides push and pop.
module fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = (PW)'(1);
    localparam logic [PW:0]    CNT_ONE = (PW+1)'(1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q;
    logic           wr_en, rd_en;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign wr_en = push_i & ~flush_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~flush_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, reads combinational imem, buffers {pc, inst} for decode (1-edge latency).
// Stalls the PC while the buffer is full and not popping; a redirect flushes and reloads the PC.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_misaligned
);

    logic [31:0]  pc_q, pc_d;
    logic         halted_q, halted_d;
    logic         full, empty, pop, push, misaligned;
    fetch_entry_t wr_entry, head;

    assign imem_addr  = pc_q;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign pop        = out_valid & out_ready;
    assign push       = ~redirect_valid & ~halted_q & (~full | pop);

    always_comb begin
        wr_entry.pc         = pc_q;
        wr_entry.inst       = misaligned ? INST_NOP : imem_data;
        wr_entry.misaligned = misaligned;
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (push) begin
            pc_d     = pc_q + 32'd4;
            // A misaligned fetch is delivered once, then fetch parks until redirected.
            halted_d = misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // Empty head shows reset-like values so stale storage never leaks out.
    assign out_valid      = ~empty;
    assign out_pc         = empty ? 32'h0 : head.pc;
    assign out_inst       = empty ? INST_NOP : head.inst;
    assign out_misaligned = ~empty & head.misaligned;

    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !redirect_valid) |=>
        (out_valid && $stable(out_pc) && $stable(out_inst) && $stable(out_misaligned)));

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;

    int           checks = 0;
    int           failures = 0;
    int           budget = 0;
    logic         force_rdy = 1'b0;
    int           cyc = 0;
    int           beat_cyc[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misaligned (out_misaligned)
    );

    // Memory image: word index i holds 32'hC0DE_0000 | i[15:0].
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[17:2]};
    endfunction
    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_e(input logic [31:0] pc, input logic [31:0] inst, input logic mis);
        fetch_entry_t e;
        e.pc = pc;
        e.inst = inst;
        e.misaligned = mis;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Ready follows the beat budget, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = (budget > 0) || force_rdy;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual pc=%h inst=%h expected none", out_pc, out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_pc", out_pc, mon_e.pc);
                chk("beat_inst", out_inst, mon_e.inst);
                chk("beat_mis", {31'b0, out_misaligned}, {31'b0, mon_e.misaligned});
            end
            if (budget > 0) budget--;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || budget != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        budget = 0;
        @(posedge clk); #1;
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        force_rdy      = rdy;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        force_rdy      = 1'b0;
    endtask

    task automatic chk_span(input string name, input int span);
        chk({name, "_beats"}, 32'(beat_cyc.size()), 32'(span + 1));
        if (beat_cyc.size() == span + 1)
            chk({name, "_span"}, 32'(beat_cyc[span] - beat_cyc[0]), 32'(span));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0000_0013);
        chk("rst_mis", {31'b0, out_misaligned}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming from reset, one beat per cycle.
        @(posedge clk); #1;
        beat_cyc.delete();
        expect_e(32'h0, 32'hC0DE_0000, 1'b0);
        expect_e(32'h4, 32'hC0DE_0001, 1'b0);
        expect_e(32'h8, 32'hC0DE_0002, 1'b0);
        expect_e(32'hC, 32'hC0DE_0003, 1'b0);
        budget = 4;
        rst_n = 1'b1;
        drain("stream_drain");
        chk_span("stream", 3);

        // Stall with buffer full: pc holds at 8, head holds pc 0.
        redirect(32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, 32'h0);
            chk("stall_addr", imem_addr, 32'h8);
        end
        @(posedge clk); #1;
        beat_cyc.delete();
        expect_e(32'h0, 32'hC0DE_0000, 1'b0);
        expect_e(32'h4, 32'hC0DE_0001, 1'b0);
        expect_e(32'h8, 32'hC0DE_0002, 1'b0);
        budget = 3;
        drain("stall_drain");
        chk_span("stall", 2);

        // Redirect against a full buffer with ready high: old entries discarded.
        @(negedge clk);
        chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        expect_e(32'h100, 32'hC0DE_0040, 1'b0);
        expect_e(32'h104, 32'hC0DE_0041, 1'b0);
        redirect(32'h100, 1'b1);
        budget = 2;
        @(negedge clk);
        chk("flush_gap_valid", {31'b0, out_valid}, 32'd0);
        drain("flush_drain");

        // Misaligned target: one NOP entry, then fetch parks.
        expect_e(32'h102, 32'h0000_0013, 1'b1);
        redirect(32'h102, 1'b0);
        budget = 1;
        drain("misal_drain");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        expect_e(32'h200, 32'hC0DE_0080, 1'b0);
        expect_e(32'h204, 32'hC0DE_0081, 1'b0);
        redirect(32'h200, 1'b0);
        budget = 2;
        drain("resume_drain");

        // PC wraps from the top of the address space.
        expect_e(32'hFFFF_FFFC, 32'hC0DE_FFFF, 1'b0);
        expect_e(32'h0000_0000, 32'hC0DE_0000, 1'b0);
        redirect(32'hFFFF_FFFC, 1'b0);
        budget = 2;
        drain("wrap_drain");

        // Asynchronous reset in mid-stream.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_inst", out_inst, 32'h0000_0013);
        chk("arst_mis", {31'b0, out_misaligned}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        expect_e(32'h0, 32'hC0DE_0000, 1'b0);
        expect_e(32'h4, 32'hC0DE_0001, 1'b0);
        budget = 2;
        rst_n = 1'b1;
        drain("restart_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
